trng_req_scheduler: RTL and testbench

//  Sequences the TRNG sampler and health monitor: warm-up, health clear, bit

---
 rtl/trng_req_scheduler.sv | 178 +++++++++++++++++
 tb/tb_trng_req_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_req_scheduler.sv
// TRNG request scheduler: sequences sampler warm-up, health clear, bit collection
// and word capture, then hands each captured word to exactly one requester.
module trng_req_scheduler #(
    parameter int N_REQ          = 2,
    parameter int WARMUP_CYCLES  = 1024,
    parameter int BITS_PER_WORD  = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [31:0]      rnd_data,
    output logic             trng_enable,
    output logic             trng_sample_trig,
    output logic             trng_clear,
    input  logic [31:0]      trng_random,
    input  logic [31:0]      trng_sample_count,
    input  logic             health_fail,
    output logic             busy,
    output logic             fault,
    output logic [15:0]      word_cnt
);

    localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RR_W-1:0]   RR_RESET  = RR_W'(N_REQ - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_CLEAR,
        S_COLLECT,
        S_TRIG,
        S_CAPTURE,
        S_READY,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       word_q, word_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [15:0]       word_cnt_d;
    logic [N_REQ-1:0]  gnt_d;
    logic [31:0]       rnd_data_d;

    logic [31:0]       delta;
    logic              arb_found;
    logic [RR_W-1:0]   arb_idx;
    logic [RR_W-1:0]   cand;

    // Modulo-2^32 subtraction keeps the bit count correct across counter wrap.
    assign delta = trng_sample_count - base_q;

    // Round-robin: scan circularly starting just after the last winner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_q;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = RR_W'((int'(rr_q) + off) % N_REQ);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        warm_d     = warm_q;
        tmo_d      = tmo_q;
        base_d     = base_q;
        word_d     = word_q;
        rr_d       = rr_q;
        word_cnt_d = word_cnt;
        gnt_d      = '0;
        rnd_data_d = '0;

        if (!cfg_enable) begin
            state_d = S_IDLE;
            word_d  = '0;
        end else if (health_fail && (state_q == S_COLLECT || state_q == S_TRIG ||
                                     state_q == S_CAPTURE || state_q == S_READY)) begin
            state_d = S_FAULT;
            word_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WARMUP;
                    warm_d  = '0;
                end
                S_WARMUP: begin
                    if (warm_q == WARM_LAST) state_d = S_CLEAR;
                    else                     warm_d  = warm_q + 1'b1;
                end
                S_CLEAR: begin
                    state_d = S_COLLECT;
                    base_d  = trng_sample_count;
                    tmo_d   = '0;
                end
                S_COLLECT: begin
                    if (delta >= 32'(BITS_PER_WORD)) state_d = S_TRIG;
                    else if (tmo_q == TMO_LAST)      state_d = S_FAULT;
                    else                             tmo_d   = tmo_q + 1'b1;
                end
                S_TRIG:    state_d = S_CAPTURE;
                S_CAPTURE: begin
                    state_d = S_READY;
                    word_d  = trng_random;
                end
                S_READY: begin
                    if (arb_found) begin
                        gnt_d[arb_idx] = 1'b1;
                        rnd_data_d     = word_q;
                        rr_d           = arb_idx;
                        word_cnt_d     = word_cnt + 16'd1;
                        word_d         = '0;
                        state_d        = S_COLLECT;
                        base_d         = trng_sample_count;
                        tmo_d          = '0;
                    end
                end
                S_FAULT:   state_d = S_FAULT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            warm_q           <= '0;
            tmo_q            <= '0;
            base_q           <= '0;
            word_q           <= '0;
            rr_q             <= RR_RESET;
            word_cnt         <= '0;
            gnt              <= '0;
            rnd_valid        <= 1'b0;
            rnd_data         <= '0;
            trng_enable      <= 1'b0;
            trng_sample_trig <= 1'b0;
            trng_clear       <= 1'b0;
            busy             <= 1'b0;
            fault            <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q          <= state_d;
            warm_q           <= warm_d;
            tmo_q            <= tmo_d;
            base_q           <= base_d;
            word_q           <= word_d;
            rr_q             <= rr_d;
            word_cnt         <= word_cnt_d;
            gnt              <= gnt_d;
            rnd_valid        <= |gnt_d;
            rnd_data         <= rnd_data_d;
            trng_enable      <= (state_d != S_IDLE) && (state_d != S_FAULT);
            trng_sample_trig <= (state_d == S_TRIG);
            trng_clear       <= (state_d == S_CLEAR);
            busy             <= (state_d != S_IDLE);
            fault            <= (state_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_trng_req_scheduler.sv
// Self-checking bench for trng_req_scheduler: a directed bring-up vector table
// followed by hand-written round-robin, wrap, fault, timeout and abort sequences.
module tb_trng_req_scheduler;

    localparam int N_REQ = 2;

    logic             clk;
    logic             rst_n;
    logic             cfg_enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rnd_valid;
    logic [31:0]      rnd_data;
    logic             trng_enable;
    logic             trng_sample_trig;
    logic             trng_clear;
    logic [31:0]      trng_random;
    logic [31:0]      count;
    logic             health_fail;
    logic             busy;
    logic             fault;
    logic [15:0]      word_cnt;

    trng_req_scheduler #(
        .N_REQ(N_REQ), .WARMUP_CYCLES(8), .BITS_PER_WORD(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .req(req),
        .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .trng_enable(trng_enable), .trng_sample_trig(trng_sample_trig),
        .trng_clear(trng_clear), .trng_random(trng_random),
        .trng_sample_count(count), .health_fail(health_fail),
        .busy(busy), .fault(fault), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        clr;
        logic        trig;
        logic        bsy;
        logic        flt;
        logic [1:0]  g;
        logic        v;
        logic [31:0] d;
        logic [15:0] w;
    } out_t;

    typedef struct {
        logic        cfg;
        logic [1:0]  rq;
        logic        hf;
        logic [31:0] cnt;
        logic [31:0] rnd;
        out_t        exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit inc_en = 1'b0;
    bit half   = 1'b0;

    logic [31:0] wrap_cnt  [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
    logic        wrap_trig [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    function automatic out_t mk(input logic en, input logic clr, input logic trig,
                                input logic bsy, input logic flt, input logic [1:0] g,
                                input logic v, input logic [31:0] d, input logic [15:0] w);
        mk = {en, clr, trig, bsy, flt, g, v, d, w};
    endfunction

    function automatic out_t sample();
        sample = {trng_enable, trng_clear, trng_sample_trig, busy, fault,
                  gnt, rnd_valid, rnd_data, word_cnt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: outputs are stable 1 time unit after the edge; the sample
    // counter model then advances by one every second cycle when enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (inc_en) begin
            half = !half;
            if (!half) count = count + 32'd1;
        end
    endtask

    // sel: 0 = trig pulse, 1 = clear pulse, 2 = grant
    task automatic wait_for(input string name, input int sel, input int max_cyc, output int waited);
        logic hit;
        hit    = 1'b0;
        waited = 0;
        while (!hit && waited < max_cyc) begin
            tick();
            waited++;
            case (sel)
                0:       hit = trng_sample_trig;
                1:       hit = trng_clear;
                default: hit = rnd_valid;
            endcase
        end
        check({name, "_seen"}, 64'(hit), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int last_gnt;
        int gap;

        // Bring-up table: enable, 8 warm-up cycles, clear, collect to +4, word delivery.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 2'b00, (i == 3), 32'd100, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'd100, 32'd0, mk(1,1,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[9]  = '{1'b1, 2'b00, 1'b1, 32'd100, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'd100, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'd101, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 32'd102, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'd103, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'd104, 32'd0, mk(1,0,1,1,0,2'b00,0,32'd0,16'd0)};
        vecs[15] = '{1'b1, 2'b00, 1'b0, 32'd104, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[16] = '{1'b1, 2'b00, 1'b0, 32'd104, 32'hA5A5_1234, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[17] = '{1'b1, 2'b00, 1'b0, 32'd104, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd0)};
        vecs[18] = '{1'b1, 2'b01, 1'b0, 32'd104, 32'd0, mk(1,0,0,1,0,2'b01,1,32'hA5A5_1234,16'd1)};
        vecs[19] = '{1'b1, 2'b00, 1'b0, 32'd105, 32'd0, mk(1,0,0,1,0,2'b00,0,32'd0,16'd1)};

        rst_n       = 1'b0;
        cfg_enable  = 1'b0;
        req         = '0;
        health_fail = 1'b0;
        trng_random = '0;
        count       = '0;
        repeat (2) tick();
        check("reset_outputs", 64'(sample()), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cfg_enable  = vecs[i].cfg;
            req         = vecs[i].rq;
            health_fail = vecs[i].hf;
            count       = vecs[i].cnt;
            trng_random = vecs[i].rnd;
            tick();
            check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
        end
        last_gnt = cyc - 1;

        // Round-robin with both requesters held; requester 0 won last.
        health_fail = 1'b0;
        inc_en      = 1'b1;
        half        = 1'b0;
        req         = 2'b11;
        for (int k = 0; k < 4; k++) begin
            trng_random = 32'hC0DE_0000 | 32'(k);
            wait_for($sformatf("rr%0d", k), 2, 40, w);
            check($sformatf("rr%0d_gnt", k), 64'(gnt), (k % 2 == 0) ? 64'd2 : 64'd1);
            check($sformatf("rr%0d_data", k), 64'(rnd_data), 64'(32'hC0DE_0000 | 32'(k)));
            gap = cyc - last_gnt;
            if (k > 0) check($sformatf("rr%0d_gap_10_to_11", k), 64'(gap >= 10 && gap <= 11), 64'd1);
            last_gnt = cyc;
        end
        req = 2'b00;
        tick();
        check("rr_gnt_one_cycle", 64'(rnd_valid), 64'd0);
        check("rr_word_cnt", 64'(word_cnt), 64'd5);

        // Sample counter wraps between base and trigger.
        trng_random = 32'h0BAD_F00D;
        wait_for("wrap_pre_trig", 0, 40, w);
        tick();
        tick();
        inc_en = 1'b0;
        count  = 32'hFFFF_FFFE;
        req    = 2'b01;
        tick();
        check("wrap_gnt", 64'(gnt), 64'd1);
        check("wrap_data", 64'(rnd_data), 64'h0BAD_F00D);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            count = wrap_cnt[i];
            tick();
            check($sformatf("wrap_trig_cnt_%h", wrap_cnt[i]), 64'(trng_sample_trig), 64'(wrap_trig[i]));
        end

        // Health failure while a word is ready and requested.
        trng_random = 32'h5555_AAAA;
        tick();
        tick();
        req         = 2'b01;
        health_fail = 1'b1;
        tick();
        check("fault_in_ready", 64'(sample()), 64'(mk(0,0,0,1,1,2'b00,0,32'd0,16'd6)));
        health_fail = 1'b0;
        req         = 2'b00;
        tick();
        check("fault_sticky", 64'(fault), 64'd1);
        cfg_enable = 1'b0;
        tick();
        check("fault_to_idle", 64'({busy, fault, trng_enable}), 64'd0);

        // Recovery re-runs warm-up and clear, then delivers normally.
        cfg_enable = 1'b1;
        wait_for("recover_clear", 1, 20, w);
        check("recover_clear_cycle", 64'(w), 64'd9);
        inc_en      = 1'b1;
        half        = 1'b0;
        trng_random = 32'h1357_9BDF;
        req         = 2'b10;
        wait_for("recover", 2, 40, w);
        check("recover_gnt", 64'(gnt), 64'd2);
        check("recover_data", 64'(rnd_data), 64'h1357_9BDF);
        check("recover_word_cnt", 64'(word_cnt), 64'd7);

        // Frozen sample counter: FAULT after exactly 64 COLLECT cycles.
        inc_en = 1'b0;
        req    = 2'b00;
        repeat (63) tick();
        check("tmo_not_yet", 64'(fault), 64'd0);
        tick();
        check("tmo_fault", 64'({fault, trng_enable}), 64'b10);

        // Abort by cfg_enable=0 while in CAPTURE.
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;
        inc_en     = 1'b1;
        wait_for("abort_trig", 0, 60, w);
        tick();
        cfg_enable = 1'b0;
        req        = 2'b01;
        tick();
        check("abort_capture", 64'(sample()), 64'(mk(0,0,0,0,0,2'b00,0,32'd0,16'd7)));

        // Asynchronous reset in the middle of COLLECT.
        req        = 2'b00;
        cfg_enable = 1'b1;
        wait_for("rst_clear", 1, 20, w);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'(sample()), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_reset_restart", 64'({busy, trng_enable, word_cnt}), 64'({2'b11, 16'd0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
